// File: rtl/onehot_encoder_seq.sv
// Sequential N_IN-to-W_OUT request encoder with a pending register and valid/ready output stage.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed highest-index priority.
module onehot_encoder_seq #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned W_OUT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req_i,
  output logic [W_OUT-1:0] code_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             dup_o,
  output logic             idle_o
);

  if (W_OUT != $clog2(N_IN)) begin : g_width_check
    $error("onehot_encoder_seq: W_OUT must equal clog2(N_IN)");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [W_OUT-1:0]   code_q, code_d;
  logic               dup_q, dup_d;
  logic [N_IN-1:0]    pend_q, pend_d;

  logic [N_IN-1:0]    cand;
  logic [N_IN-1:0]    sel_mask;
  logic [W_OUT-1:0]   sel;
  logic [W_OUT-1:0]   scan_idx;
  logic               load;

`ifdef ROUND_ROBIN_EN
  logic [W_OUT-1:0]   rr_last_q, rr_last_d;
  int unsigned        rr_idx;
  logic               found;
`endif

  assign cand = pend_q | req_i;
  assign load = (state_q == EMPTY) | ready_i;

  // Arbitration over cand; only meaningful when cand != 0.
  always_comb begin
    sel      = '0;
    scan_idx = '0;
`ifdef ROUND_ROBIN_EN
    rr_idx = 0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      rr_idx   = (32'(rr_last_q) + 32'd1 + i) % N_IN;
      scan_idx = W_OUT'(rr_idx);
      if (!found && cand[scan_idx]) begin
        sel   = scan_idx;
        found = 1'b1;
      end
    end
`else
    // Ascending scan; the last hit is the highest set index.
    for (int unsigned i = 0; i < N_IN; i++) begin
      scan_idx = W_OUT'(i);
      if (cand[scan_idx]) sel = scan_idx;
    end
`endif
    sel_mask      = '0;
    sel_mask[sel] = 1'b1;
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pend_d  = pend_q;
    dup_d   = |(req_i & pend_q);
`ifdef ROUND_ROBIN_EN
    rr_last_d = rr_last_q;
`endif
    if (load) begin
      if (cand != '0) begin
        state_d = FULL;
        code_d  = sel;
        pend_d  = cand & ~sel_mask;
`ifdef ROUND_ROBIN_EN
        rr_last_d = sel;
`endif
      end else begin
        state_d = EMPTY;
        pend_d  = '0;
      end
    end else begin
      pend_d = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      code_q  <= '0;
      dup_q   <= 1'b0;
      pend_q  <= '0;
`ifdef ROUND_ROBIN_EN
      rr_last_q <= W_OUT'(N_IN - 1);
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dup_q   <= dup_d;
      pend_q  <= pend_d;
`ifdef ROUND_ROBIN_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  always_comb begin
    valid_o = (state_q == FULL);
    code_o  = code_q;
    dup_o   = dup_q;
    idle_o  = (state_q == EMPTY) && (pend_q == '0);
  end

endmodule
